// File: rtl/beep_arbiter.sv
// beep_arbiter: three-requester fixed-priority tone player.
// Requester 0 has the highest priority. A grant latches that requester's
// half-period and beat count, plays a square wave on oSND for BEATS beats,
// then holds a silent gap before it accepts the next request.
// All outputs come straight from registers.
module beep_arbiter #(
  parameter int BEAT_DIV = 6250000,
  parameter int GAP_CYC  = 625000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [2:0]  iREQ,
  input  logic [15:0] iHALF0,
  input  logic [15:0] iHALF1,
  input  logic [15:0] iHALF2,
  input  logic [3:0]  iBEATS0,
  input  logic [3:0]  iBEATS1,
  input  logic [3:0]  iBEATS2,
  output logic [2:0]  oACK,
  output logic [1:0]  oOWNER,
  output logic        oBUSY,
  output logic        oSND
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [1:0] NO_OWNER = 2'd3;

  // The beat prescaler counts 0..BEAT_DIV-1 and the gap counter counts
  // 0..GAP_CYC-1, so neither can wrap inside its state.
  localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam bit HAS_GAP = (GAP_CYC > 0);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]    beat_idx_q, beat_idx_d;
  logic [15:0]   half_cnt_q, half_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]   half_q, half_d;
  logic [3:0]    beats_q, beats_d;
  logic [1:0]    owner_d;
  logic [2:0]    ack_d;
  logic          busy_d;
  logic          snd_d;

  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [2:0]    grant_oh;
  logic [15:0]   half_sel;
  logic [3:0]    beats_sel;
  logic          play_last;

  // Fixed priority: lowest set request index wins, and its operands are selected.
  always_comb begin
    grant_valid = |iREQ;
    grant_idx   = 2'd0;
    grant_oh    = 3'b000;
    half_sel    = 16'd0;
    beats_sel   = 4'd0;
    if (iREQ[0]) begin
      grant_idx = 2'd0;
      grant_oh  = 3'b001;
      half_sel  = iHALF0;
      beats_sel = iBEATS0;
    end else if (iREQ[1]) begin
      grant_idx = 2'd1;
      grant_oh  = 3'b010;
      half_sel  = iHALF1;
      beats_sel = iBEATS1;
    end else if (iREQ[2]) begin
      grant_idx = 2'd2;
      grant_oh  = 3'b100;
      half_sel  = iHALF2;
      beats_sel = iBEATS2;
    end
  end

  // Last PLAY cycle: a zero-beat tone plays for a single cycle, otherwise
  // it is the final prescaler count of the final beat.
  always_comb begin
    play_last = (beats_q == 4'd0) ||
                ((beat_idx_q == (beats_q - 4'd1)) && (beat_cnt_q == BEAT_LAST));
  end

  // Next-state logic for the FSM, counters, latched operands and outputs.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beat_idx_d = beat_idx_q;
    half_cnt_d = half_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    half_d     = half_q;
    beats_d    = beats_q;
    owner_d    = oOWNER;
    ack_d      = 3'b000;
    snd_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        owner_d = NO_OWNER;
        if (grant_valid) begin
          // Requests are only looked at here, so a tone is never preempted.
          state_d    = S_PLAY;
          half_d     = half_sel;
          beats_d    = beats_sel;
          owner_d    = grant_idx;
          ack_d      = grant_oh;
          beat_cnt_d = '0;
          beat_idx_d = 4'd0;
          half_cnt_d = 16'd0;
          gap_cnt_d  = '0;
        end
      end

      S_PLAY: begin
        if (play_last) begin
          beat_cnt_d = '0;
          beat_idx_d = 4'd0;
          half_cnt_d = 16'd0;
          gap_cnt_d  = '0;
          // A zero-beat tone skips the gap entirely.
          if ((beats_q != 4'd0) && HAS_GAP) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            owner_d = NO_OWNER;
          end
        end else begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            beat_idx_d = beat_idx_q + 4'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          // Half-period of zero is a rest: the output never leaves 0.
          if (half_q != 16'd0) begin
            if (half_cnt_q == (half_q - 16'd1)) begin
              half_cnt_d = 16'd0;
              snd_d      = ~oSND;
            end else begin
              half_cnt_d = half_cnt_q + 16'd1;
              snd_d      = oSND;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          owner_d   = NO_OWNER;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        owner_d = NO_OWNER;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any tone immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      beat_idx_q <= 4'd0;
      half_cnt_q <= 16'd0;
      gap_cnt_q  <= '0;
      half_q     <= 16'd0;
      beats_q    <= 4'd0;
      oACK       <= 3'b000;
      oOWNER     <= NO_OWNER;
      oBUSY      <= 1'b0;
      oSND       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beat_idx_q <= beat_idx_d;
      half_cnt_q <= half_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      half_q     <= half_d;
      beats_q    <= beats_d;
      oACK       <= ack_d;
      oOWNER     <= owner_d;
      oBUSY      <= busy_d;
      oSND       <= snd_d;
    end
  end

endmodule

// File: tb/tb_beep_arbiter.sv
// Directed, table-driven bench for beep_arbiter with BEAT_DIV=10, GAP_CYC=4.
module tb_beep_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [2:0]  iREQ = 3'b000;
  logic [15:0] iHALF0 = 16'd0, iHALF1 = 16'd0, iHALF2 = 16'd0;
  logic [3:0]  iBEATS0 = 4'd0, iBEATS1 = 4'd0, iBEATS2 = 4'd0;
  logic [2:0]  oACK;
  logic [1:0]  oOWNER;
  logic        oBUSY;
  logic        oSND;

  beep_arbiter #(.BEAT_DIV(10), .GAP_CYC(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ),
    .iHALF0(iHALF0), .iHALF1(iHALF1), .iHALF2(iHALF2),
    .iBEATS0(iBEATS0), .iBEATS1(iBEATS1), .iBEATS2(iBEATS2),
    .oACK(oACK), .oOWNER(oOWNER), .oBUSY(oBUSY), .oSND(oSND)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0]  req;        // driven in the IDLE cycle before the grant edge
    logic [2:0]  req_after;  // driven from the first PLAY cycle
    logic [2:0]  req_late;   // driven at PLAY cycle late_t
    int          late_t;
    logic [15:0] h0, h1, h2;
    logic [3:0]  b0, b1, b2;
    int          owner;      // expected winner
    int          half;       // expected latched half-period
    int          play;       // expected PLAY cycles
    int          gap;        // expected GAP cycles
  } vec_t;

  vec_t vecs [10];
  int n_applied = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_applied++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // following idle cycle.
  task automatic run_vec(input vec_t v, input int id);
    int exp_snd;
    iREQ = v.req;
    iHALF0 = v.h0; iHALF1 = v.h1; iHALF2 = v.h2;
    iBEATS0 = v.b0; iBEATS1 = v.b1; iBEATS2 = v.b2;
    @(negedge iCLK);
    for (int t = 0; t < v.play; t++) begin
      if (t == 0) iREQ = v.req_after;
      if (t == v.late_t) iREQ = v.req_late;
      exp_snd = (v.half == 0) ? 0 : ((t / v.half) % 2);
      chk($sformatf("v%0d play ack t%0d", id, t), int'(oACK), (t == 0) ? (1 << v.owner) : 0);
      chk($sformatf("v%0d play owner t%0d", id, t), int'(oOWNER), v.owner);
      chk($sformatf("v%0d play busy t%0d", id, t), int'(oBUSY), 1);
      chk($sformatf("v%0d play snd t%0d", id, t), int'(oSND), exp_snd);
      @(negedge iCLK);
    end
    for (int g = 0; g < v.gap; g++) begin
      chk($sformatf("v%0d gap owner g%0d", id, g), int'(oOWNER), v.owner);
      chk($sformatf("v%0d gap busy g%0d", id, g), int'(oBUSY), 1);
      chk($sformatf("v%0d gap snd g%0d", id, g), int'(oSND), 0);
      chk($sformatf("v%0d gap ack g%0d", id, g), int'(oACK), 0);
      @(negedge iCLK);
    end
    chk($sformatf("v%0d idle busy", id), int'(oBUSY), 0);
    chk($sformatf("v%0d idle owner", id), int'(oOWNER), 3);
    chk($sformatf("v%0d idle ack", id), int'(oACK), 0);
    chk($sformatf("v%0d idle snd", id), int'(oSND), 0);
    $display("vec %0d: req=%b owner=%0d half=%0d play=%0d gap=%0d errors_so_far=%0d",
             id, v.req, v.owner, v.half, v.play, v.gap, n_err);
  endtask

  initial begin
    //         req     after   late    lt  h0  h1  h2  b0 b1 b2 own half play gap
    vecs[0] = '{3'b010, 3'b000, 3'b000, 0, 0,  3,  0,  0, 2, 0, 1, 3,  20, 4};
    vecs[1] = '{3'b111, 3'b111, 3'b111, 0, 2,  5,  7,  1, 1, 1, 0, 2,  10, 4};
    vecs[2] = '{3'b111, 3'b111, 3'b111, 0, 2,  5,  7,  1, 1, 1, 0, 2,  10, 4};
    vecs[3] = '{3'b111, 3'b110, 3'b110, 0, 2,  5,  7,  1, 1, 1, 0, 2,  10, 4};
    vecs[4] = '{3'b110, 3'b000, 3'b000, 0, 2,  5,  7,  1, 1, 1, 1, 5,  10, 4};
    vecs[5] = '{3'b100, 3'b000, 3'b000, 0, 0,  0,  0,  0, 0, 3, 2, 0,  30, 4};
    vecs[6] = '{3'b100, 3'b000, 3'b000, 0, 0,  0,  9,  0, 0, 0, 2, 9,  1,  0};
    vecs[7] = '{3'b100, 3'b001, 3'b001, 0, 1,  0,  4,  1, 0, 1, 2, 4,  10, 4};
    vecs[8] = '{3'b001, 3'b000, 3'b000, 0, 1,  0,  0,  1, 0, 0, 0, 1,  10, 4};
    vecs[9] = '{3'b001, 3'b010, 3'b000, 5, 2,  6,  0,  1, 2, 0, 0, 2,  10, 4};

    // Reset state while reset is held.
    repeat (3) @(negedge iCLK);
    chk("reset ack", int'(oACK), 0);
    chk("reset owner", int'(oOWNER), 3);
    chk("reset busy", int'(oBUSY), 0);
    chk("reset snd", int'(oSND), 0);

    // Release reset; the first edge afterwards samples the request.
    iRST = 1'b0;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Requester 1 was withdrawn mid-tone in vec 9: nothing is granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      chk($sformatf("withdrawn ack c%0d", i), int'(oACK), 0);
      chk($sformatf("withdrawn busy c%0d", i), int'(oBUSY), 0);
    end

    // Reset in the middle of a tone.
    iREQ = 3'b010; iHALF1 = 16'd2; iBEATS1 = 4'd3;
    @(negedge iCLK);
    chk("rst-mid ack", int'(oACK), 2);
    iREQ = 3'b000;
    repeat (7) @(negedge iCLK);
    chk("rst-mid snd before reset", int'(oSND), 1);
    iRST = 1'b1;
    #1;
    chk("rst-mid async ack", int'(oACK), 0);
    chk("rst-mid async owner", int'(oOWNER), 3);
    chk("rst-mid async busy", int'(oBUSY), 0);
    chk("rst-mid async snd", int'(oSND), 0);
    @(negedge iCLK);
    iRST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      chk($sformatf("post-rst snd c%0d", i), int'(oSND), 0);
      chk($sformatf("post-rst busy c%0d", i), int'(oBUSY), 0);
      chk($sformatf("post-rst ack c%0d", i), int'(oACK), 0);
    end
    $display("reset mid-tone sequence: errors_so_far=%0d", n_err);

    // Normal operation resumes with a fresh request.
    run_vec(vecs[8], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
